fifo_wr_ctrl: RTL and testbench

//  Packet-capture write path: 512x32 show-ahead FIFO buffers captured words; a write

---
 rtl/fifo_wr_ctrl.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_fifo_wr_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl.sv
// fifo_sa: generic show-ahead FIFO; head word is always visible on rd_dat while count != 0.
// Latency: a write is visible at the head one cycle after it is accepted; a read pops on the same edge.
// Backpressure: writes are dropped when full, and reads are ignored when empty.
// Ports: wr_dat/wr_vld push, rd_en pop, rd_dat head word, count occupancy (0..DEPTH).
// DEPTH must be a power of two because the pointers wrap naturally.
module fifo_sa #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 512,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] wr_dat,
   input  logic              wr_vld,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_dat,
   output logic [AW:0]       count
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic              do_wr, do_rd;

   always_comb begin
      do_wr    = wr_vld && (count_q != FULL_CNT);
      do_rd    = rd_en && (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_wr) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_rd) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_wr && !do_rd) begin
         count_d = count_q + (AW+1)'(1);
      end else if (do_rd && !do_wr) begin
         count_d = count_q - (AW+1)'(1);
      end
   end

   // Storage is not reset: after a reset the pointers make the old contents unreachable.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= wr_dat;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rd_dat = mem_q[rd_ptr_q];
   assign count  = count_q;

endmodule

// fifo_wr_ctrl: a capture FIFO is drained one packet per wr_ctrl request into memory as Avalon-MM bursts.
// Latency: the first beat is driven 3 cycles after wr_ctrl when a full burst is already buffered; each later beat follows one per cycle.
// Backpressure: waitrequest stalls the current beat indefinitely with address/burstcount/writedata held; wrreq is dropped when full.
// Ports: fifo_in/wrreq capture side with empty/almost_full/usedw status;
//        wr_ctrl/control/pkt_begin/pkt_end/write_address request a packet, and wr_ctrl_rdy reports completion;
//        address/writedata/write/burstcount/waitrequest form the Avalon-MM write master.
module fifo_wr_ctrl #(
   parameter  int DATA_W     = 32,
   parameter  int FIFO_DEPTH = 512,
   parameter  int MAX_BURST  = 8,
   localparam int USEDW_W    = $clog2(FIFO_DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] fifo_in,
   input  logic              wrreq,
   output logic              empty,
   output logic              almost_full,
   output logic [USEDW_W-1:0] usedw,
   input  logic              wr_ctrl,
   input  logic [31:0]       control,
   input  logic [31:0]       pkt_begin,
   input  logic [31:0]       pkt_end,
   input  logic [31:0]       write_address,
   output logic              wr_ctrl_rdy,
   output logic [31:0]       address,
   output logic [DATA_W-1:0] writedata,
   output logic              write,
   output logic [15:0]       burstcount,
   input  logic              waitrequest
);

   localparam int                 BYTE_SH = $clog2(DATA_W/8);
   localparam logic [31:0]        MAX_B   = 32'(MAX_BURST);
   localparam logic [USEDW_W:0]   AF_LVL  = (USEDW_W+1)'(FIFO_DEPTH-8);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT_DATA,
      BURST,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       control_unused_q, control_unused_d;
   logic [31:0]       words_q, words_d;        // packet length latched at start
   logic [31:0]       base_q, base_d;          // write_address latched at start
   logic [31:0]       rem_q, rem_d;            // words still to be written
   logic [31:0]       addr_q, addr_d;          // byte address of the next burst
   logic [31:0]       address_q, address_d;
   logic [DATA_W-1:0] writedata_q, writedata_d;
   logic              write_q, write_d;
   logic [15:0]       burstcount_q, burstcount_d;
   logic [15:0]       beats_q, beats_d;        // beats left in current burst
   logic              rdy_q, rdy_d;

   logic [DATA_W-1:0] fifo_q;
   logic [USEDW_W:0]  fifo_cnt;
   logic              fifo_pop;

   logic [31:0]       pkt_bytes;
   logic [32:0]       bytes_rnd;
   logic [31:0]       pkt_words;
   logic [15:0]       burst_n;
   logic              have_burst;
   logic              beat_acc;

   fifo_sa #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (reset),
      .wr_dat (fifo_in),
      .wr_vld (wrreq),
      .rd_en  (fifo_pop),
      .rd_dat (fifo_q),
      .count  (fifo_cnt)
   );

   // Round the byte span up to whole words.  Use 33 bits so a span near 2^32 does not overflow.
   always_comb begin
      pkt_bytes = pkt_end - pkt_begin;
      bytes_rnd = {1'b0, pkt_bytes} + 33'((DATA_W/8) - 1);
      pkt_words = (pkt_end > pkt_begin) ? 32'(bytes_rnd >> BYTE_SH) : '0;
   end

   // Start a burst only when every beat is already buffered.  This keeps write
   // asserted for the whole burst without depending on the capture side.
   assign burst_n    = (rem_q < MAX_B) ? rem_q[15:0] : MAX_B[15:0];
   assign have_burst = 32'(fifo_cnt) >= 32'(burst_n);
   assign beat_acc   = write_q && !waitrequest;

   always_comb begin
      state_d          = state_q;
      control_unused_d = control_unused_q;
      words_d          = words_q;
      base_d           = base_q;
      rem_d            = rem_q;
      addr_d           = addr_q;
      address_d        = address_q;
      writedata_d      = writedata_q;
      write_d          = write_q;
      burstcount_d     = burstcount_q;
      beats_d          = beats_q;
      rdy_d            = rdy_q;
      fifo_pop         = 1'b0;

      case (state_q)
         IDLE: begin
            if (wr_ctrl) begin
               control_unused_d = control;
               words_d          = pkt_words;
               base_d           = write_address;
               state_d          = LOAD;
            end
         end
         LOAD: begin
            rem_d  = words_q;
            addr_d = base_q;
            if (words_q == '0) begin
               rdy_d   = 1'b1;
               state_d = DONE;
            end else begin
               state_d = WAIT_DATA;
            end
         end
         WAIT_DATA: begin
            if (have_burst) begin
               address_d    = addr_q;
               burstcount_d = burst_n;
               beats_d      = burst_n;
               writedata_d  = fifo_q;
               fifo_pop     = 1'b1;
               write_d      = 1'b1;
               state_d      = BURST;
            end
         end
         BURST: begin
            if (beat_acc) begin
               if (beats_q == 16'd1) begin
                  // The last beat was popped when it was loaded, so nothing is popped here.
                  write_d = 1'b0;
                  beats_d = '0;
                  addr_d  = addr_q + (32'(burstcount_q) << BYTE_SH);
                  rem_d   = rem_q - 32'(burstcount_q);
                  if (rem_q == 32'(burstcount_q)) begin
                     rdy_d   = 1'b1;
                     state_d = DONE;
                  end else begin
                     state_d = WAIT_DATA;
                  end
               end else begin
                  writedata_d = fifo_q;
                  fifo_pop    = 1'b1;
                  beats_d     = beats_q - 16'd1;
               end
            end
         end
         DONE: begin
            write_d = 1'b0;
            if (!wr_ctrl) begin
               rdy_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            write_d = 1'b0;
            rdy_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         control_unused_q <= '0;
         words_q          <= '0;
         base_q           <= '0;
         rem_q            <= '0;
         addr_q           <= '0;
         address_q        <= '0;
         writedata_q      <= '0;
         write_q          <= 1'b0;
         burstcount_q     <= '0;
         beats_q          <= '0;
         rdy_q            <= 1'b0;
      end else begin
         state_q          <= state_d;
         control_unused_q <= control_unused_d;
         words_q          <= words_d;
         base_q           <= base_d;
         rem_q            <= rem_d;
         addr_q           <= addr_d;
         address_q        <= address_d;
         writedata_q      <= writedata_d;
         write_q          <= write_d;
         burstcount_q     <= burstcount_d;
         beats_q          <= beats_d;
         rdy_q            <= rdy_d;
      end
   end

   // usedw is USEDW_W bits wide, so it reads 0 when the FIFO holds exactly FIFO_DEPTH words.
   // The full-depth count stays internal, and almost_full and empty disambiguate that case.
   assign empty       = (fifo_cnt == '0);
   assign almost_full = (fifo_cnt >= AF_LVL);
   assign usedw       = fifo_cnt[USEDW_W-1:0];
   assign wr_ctrl_rdy = rdy_q;
   assign address     = address_q;
   assign writedata   = writedata_q;
   assign write       = write_q;
   assign burstcount  = burstcount_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
`timescale 1ns/1ps
module tb_fifo_wr_ctrl;

   localparam int MAXB = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] fifo_in = '0;
   logic        wrreq = 1'b0;
   logic        empty, almost_full;
   logic [8:0]  usedw;
   logic        wr_ctrl = 1'b0;
   logic [31:0] control = '0, pkt_begin = '0, pkt_end = '0, write_address = '0;
   logic        wr_ctrl_rdy;
   logic [31:0] address, writedata;
   logic        write;
   logic [15:0] burstcount;
   logic        waitrequest = 1'b0;

   fifo_wr_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .fifo_in       (fifo_in),
      .wrreq         (wrreq),
      .empty         (empty),
      .almost_full   (almost_full),
      .usedw         (usedw),
      .wr_ctrl       (wr_ctrl),
      .control       (control),
      .pkt_begin     (pkt_begin),
      .pkt_end       (pkt_end),
      .write_address (write_address),
      .wr_ctrl_rdy   (wr_ctrl_rdy),
      .address       (address),
      .writedata     (writedata),
      .write         (write),
      .burstcount    (burstcount),
      .waitrequest   (waitrequest)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [15:0] bc;
      logic [31:0] data;
   } beat_t;

   typedef struct {
      int          prefill;
      logic [31:0] pb;
      logic [31:0] pe;
      logic [31:0] wa;
      int          words;
      int          smode;
      logic [8:0]  exp_usedw;
   } vec_t;

   beat_t       sb[$];        // expected Avalon beats in order
   logic [31:0] mq[$];        // model of FIFO contents
   int          n_cmp = 0;
   int          n_fail = 0;
   int          mon_beat = 0;
   int          write_cycles = 0;
   int          stall_mode = 0;
   int          stall_cnt = 0;
   int          stall_last = 0;
   logic [31:0] next_val = 32'd10;
   vec_t        tbl[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: sample at the falling edge, then compare each presented beat with the scoreboard head.
   always @(negedge clk) begin
      beat_t e;
      if (reset) begin
         mon_beat = 0;
      end else if (write) begin
         write_cycles++;
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_write: address 0x%0h data 0x%0h, expected no write", address, writedata);
         end else begin
            e = sb[0];
            check("beat_address", address, e.addr);
            check("beat_burstcount", 32'(burstcount), 32'(e.bc));
            check("beat_writedata", writedata, e.data);
            if (!waitrequest) begin
               void'(sb.pop_front());
               mon_beat++;
               if (mon_beat == int'(burstcount)) mon_beat = 0;
            end
         end
      end else if (mon_beat != 0) begin
         check("write_held_in_burst", 32'(write), 32'd1);
      end
   end

   // waitrequest driver: mode 0 none, 1 two-cycle stalls on beats 2 and 5, 2 random, 3 always stalled.
   always @(posedge clk) begin
      #1;
      if (mon_beat != stall_last) begin
         stall_cnt  = 0;
         stall_last = mon_beat;
      end
      case (stall_mode)
         0: waitrequest = 1'b0;
         1: begin
            if (write && (mon_beat == 1 || mon_beat == 4) && stall_cnt < 2) begin
               waitrequest = 1'b1;
               stall_cnt++;
            end else begin
               waitrequest = 1'b0;
            end
         end
         2: waitrequest = ($urandom_range(0, 3) == 0);
         default: waitrequest = 1'b1;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_words(input int n);
      for (int i = 0; i < n; i++) begin
         fifo_in = next_val;
         wrreq   = 1'b1;
         if (mq.size() < 512) mq.push_back(next_val);
         next_val++;
         tick();
      end
      wrreq = 1'b0;
   endtask

   task automatic expect_pkt(input logic [31:0] wa, input int words);
      int          rem = words;
      logic [31:0] ba = wa;
      int          n;
      beat_t       b;
      while (rem > 0) begin
         n = (rem < MAXB) ? rem : MAXB;
         for (int k = 0; k < n; k++) begin
            b.addr = ba;
            b.bc   = 16'(n);
            b.data = (mq.size() != 0) ? mq.pop_front() : '0;
            sb.push_back(b);
         end
         ba  = ba + 32'(4 * n);
         rem = rem - n;
      end
   endtask

   task automatic wait_rdy(input string tag, input int limit);
      int i = 0;
      while (!wr_ctrl_rdy && i < limit) begin
         @(negedge clk);
         i++;
      end
      check({tag, "_rdy"}, 32'(wr_ctrl_rdy), 32'd1);
   endtask

   task automatic run_pkt(input logic [31:0] pb, input logic [31:0] pe, input logic [31:0] wa,
                          input int words, input logic [8:0] exp_usedw, input string tag);
      pkt_begin     = pb;
      pkt_end       = pe;
      write_address = wa;
      control       = $urandom;
      expect_pkt(wa, words);
      wr_ctrl = 1'b1;
      wait_rdy(tag, 2000);
      check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
      check({tag, "_usedw"}, 32'(usedw), 32'(exp_usedw));
      tick();
      wr_ctrl = 1'b0;
      tick();
      tick();
      check({tag, "_rdy_clear"}, 32'(wr_ctrl_rdy), 32'd0);
   endtask

   task automatic wait_write(input int limit);
      int i = 0;
      while (!write && i < limit) begin
         @(negedge clk);
         i++;
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached before the test completed");
      $fatal(1, "watchdog");
   end

   initial begin
      //            prefill pb            pe           wa            words mode usedw
      tbl[0] = '{16, 32'd0,         32'd32,  32'h0000_8000, 8,  0, 9'd8};  // first burst, data 10..17
      tbl[1] = '{12, 32'd0,         32'd80,  32'h0000_8000, 20, 2, 9'd0};  // bursts 8,8,4
      tbl[2] = '{3,  32'd0,         32'd1,   32'h0000_0100, 1,  0, 9'd2};  // 1 byte rounds up
      tbl[3] = '{0,  32'd4,         32'd9,   32'h0000_0200, 2,  2, 9'd0};  // 5 bytes -> 2 words
      tbl[4] = '{10, 32'd3,         32'd40,  32'h0000_0300, 10, 0, 9'd0};  // 37 bytes -> 10 words
      tbl[5] = '{9,  32'd100,       32'd50,  32'h0000_0400, 0,  0, 9'd9};  // end < begin
      tbl[6] = '{0,  32'hFFFF_FFF0, 32'h10,  32'h0000_0500, 0,  0, 9'd9};  // end < begin, unsigned
      tbl[7] = '{7,  32'd0,         32'd64,  32'hFFFF_FFF0, 16, 2, 9'd0};  // address wraps
      tbl[8] = '{9,  32'd0,         32'd36,  32'h0000_1000, 9,  0, 9'd0};  // bursts 8,1

      // Check the reset state.
      tick();
      tick();
      check("rst_write", 32'(write), 32'd0);
      check("rst_address", address, 32'd0);
      check("rst_writedata", writedata, 32'd0);
      check("rst_burstcount", 32'(burstcount), 32'd0);
      check("rst_rdy", 32'(wr_ctrl_rdy), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_usedw", 32'(usedw), 32'd0);
      check("rst_almost_full", 32'(almost_full), 32'd0);
      reset = 1'b0;
      tick();

      for (int v = 0; v < 9; v++) begin
         stall_mode = tbl[v].smode;
         push_words(tbl[v].prefill);
         run_pkt(tbl[v].pb, tbl[v].pe, tbl[v].wa, tbl[v].words, tbl[v].exp_usedw,
                 $sformatf("vec%0d", v));
      end
      stall_mode = 0;

      // Zero-length packet: ready comes quickly, with no write and no FIFO change.
      push_words(5);
      pkt_begin = 32'd0;
      pkt_end   = 32'd0;
      wr_ctrl   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (wr_ctrl_rdy) break;
      end
      check("zero_len_rdy", 32'(wr_ctrl_rdy), 32'd1);
      check("zero_len_usedw", 32'(usedw), 32'd5);
      wr_ctrl = 1'b0;
      tick();
      tick();

      // Stalls on beats 2 and 5 add four held cycles to the eight beats.
      push_words(3);
      stall_mode   = 1;
      write_cycles = 0;
      run_pkt(32'd0, 32'd32, 32'h0000_4000, 8, 9'd0, "stall");
      check("stall_write_cycles", 32'(write_cycles), 32'd12);
      stall_mode = 0;

      // Underfilled FIFO: no write until a whole burst is buffered, and wr_ctrl dropping mid-packet is ignored.
      push_words(5);
      pkt_begin     = 32'd0;
      pkt_end       = 32'd32;
      write_address = 32'h0000_6000;
      wr_ctrl       = 1'b1;
      write_cycles  = 0;
      repeat (10) tick();
      check("underfill_no_write", 32'(write_cycles), 32'd0);
      check("underfill_usedw", 32'(usedw), 32'd5);
      push_words(3);
      expect_pkt(32'h0000_6000, 8);
      wait_write(20);
      check("underfill_burst_start", 32'(write), 32'd1);
      tick();
      wr_ctrl = 1'b0;
      wait_rdy("underfill", 200);
      check("underfill_sb_drained", 32'(sb.size()), 32'd0);
      check("underfill_usedw_end", 32'(usedw), 32'd0);
      tick();
      tick();
      check("underfill_rdy_clear", 32'(wr_ctrl_rdy), 32'd0);

      // Asynchronous reset in the middle of a stalled burst.
      push_words(8);
      stall_mode    = 3;
      pkt_begin     = 32'd0;
      pkt_end       = 32'd32;
      write_address = 32'h0000_7000;
      expect_pkt(32'h0000_7000, 8);
      wr_ctrl = 1'b1;
      wait_write(20);
      check("abort_burst_started", 32'(write), 32'd1);
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      check("abort_write", 32'(write), 32'd0);
      check("abort_usedw", 32'(usedw), 32'd0);
      check("abort_empty", 32'(empty), 32'd1);
      check("abort_rdy", 32'(wr_ctrl_rdy), 32'd0);
      check("abort_burstcount", 32'(burstcount), 32'd0);
      sb.delete();
      mq.delete();
      wr_ctrl    = 1'b0;
      stall_mode = 0;
      tick();
      reset = 1'b0;
      tick();

      // Fill to capacity: almost_full threshold, usedw wrap at 512, extra writes dropped.
      push_words(503);
      check("fill503_almost_full", 32'(almost_full), 32'd0);
      check("fill503_usedw", 32'(usedw), 32'd503);
      push_words(1);
      check("fill504_almost_full", 32'(almost_full), 32'd1);
      push_words(8);
      check("full_usedw", 32'(usedw), 32'(9'(mq.size())));
      check("full_empty", 32'(empty), 32'd0);
      push_words(4);
      check("full_drop_usedw", 32'(usedw), 32'(9'(mq.size())));
      check("full_drop_almost_full", 32'(almost_full), 32'd1);
      run_pkt(32'd0, 32'd4, 32'h0000_A000, 1, 9'd511, "full_one");
      run_pkt(32'd0, 32'd2044, 32'h0000_B000, 511, 9'd0, "full_drain");
      check("drain_empty", 32'(empty), 32'd1);
      check("drain_almost_full", 32'(almost_full), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
